// File: rtl/frame_pad_source_pkg.sv
// Shared video package for the frame padding source.
// Holds the raster geometry, counter width, input buffer depth and the
// FSM state encoding used by frame_pad_source.
package frame_pad_source_pkg;

  localparam int unsigned TOTAL_COLS  = 1201;
  localparam int unsigned TOTAL_ROWS  = 1201;
  localparam int unsigned ACTIVE_COLS = 800;
  localparam int unsigned ACTIVE_ROWS = 600;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned CNT_W       = 13;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True when (row, col) lies inside the active window; full-width compare.
  function automatic logic in_window(input cnt_t row, input cnt_t col,
                                     input cnt_t act_rows, input cnt_t act_cols);
    return (row < act_rows) && (col < act_cols);
  endfunction

endpackage

// File: rtl/frame_pad_source_fifo.sv
// pixel_fifo: small synchronous FIFO buffering compact input pixels.
// No write-to-read bypass: data written at an edge is visible at rd_data
// only after that edge. DEPTH must be a power of two (pointers wrap freely).
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   wr_en, wr_data      write strobe/data (ignored while full)
//   rd_en               pop strobe (ignored while empty)
//   rd_data             current head entry
//   full, empty, count  registered occupancy status
module pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_wr;
  logic             do_rd;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
  assign count = occ;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous read and write leaves occupancy unchanged; a read
      // while full frees its slot only from the next cycle on.
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/frame_pad_source.sv
// frame_pad_source: expands a compact ACTIVE_COLS x ACTIVE_ROWS pixel
// stream into a full TOTAL_COLS x TOTAL_ROWS raster, inserting 0-valued
// blanking pixels outside the active window.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_pixel/in_valid     compact active pixels in raster order
//   in_ready              input accepted this cycle (buffer not full)
//   out_pixel/out_valid   padded raster beat
//   out_ready             downstream accepts the beat
//   out_active            beat lies in the active window
//   out_sof               beat is row 0, col 0
//   out_eol               beat is the last column of a line
module frame_pad_source #(
  parameter int unsigned TOTAL_COLS  = frame_pad_source_pkg::TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = frame_pad_source_pkg::TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = frame_pad_source_pkg::ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = frame_pad_source_pkg::ACTIVE_ROWS,
  parameter int unsigned FIFO_DEPTH  = frame_pad_source_pkg::FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_active,
  output logic       out_sof,
  output logic       out_eol
);

  import frame_pad_source_pkg::*;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam cnt_t LAST_COL = cnt_t'(TOTAL_COLS - 1);
  localparam cnt_t LAST_ROW = cnt_t'(TOTAL_ROWS - 1);
  localparam cnt_t ACT_COLS = cnt_t'(ACTIVE_COLS);
  localparam cnt_t ACT_ROWS = cnt_t'(ACTIVE_ROWS);

  state_t      state;
  state_t      state_next;
  cnt_t        row;
  cnt_t        col;
  logic        active_beat;
  logic        out_fire;
  logic        pop;

  logic        fifo_wr;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  assign in_ready = !fifo_full;
  assign fifo_wr  = in_valid && in_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (in_pixel),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign active_beat = in_window(row, col, ACT_ROWS, ACT_COLS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_pixel  = '0;
    out_active = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (active_beat) begin
          // Underflow stalls the raster: no beat until a pixel arrives.
          out_valid = !fifo_empty;
          if (!fifo_empty) begin
            out_pixel  = fifo_head;
            out_active = 1'b1;
            pop        = out_ready;
          end
        end else begin
          out_valid = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign out_fire = out_valid && out_ready;

  // Counters move only on an output transfer, so every marker and pixel
  // stays stable while downstream holds off.
  always_ff @(posedge clock) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (out_fire) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (row == LAST_ROW) begin
          row <= '0;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign out_sof = out_valid && (row == '0) && (col == '0);
  assign out_eol = out_valid && (col == LAST_COL);

endmodule

// File: tb/tb_frame_pad_source.sv
// Self-checking bench for frame_pad_source on a reduced raster.
// Reference model: a queue of accepted pixels plus a frame beat index;
// expected row/col, window membership and markers come from arithmetic on
// the beat index.
module tb_frame_pad_source;

  localparam int unsigned TC    = 12;
  localparam int unsigned TR    = 8;
  localparam int unsigned AC    = 7;
  localparam int unsigned AR    = 5;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_active;
  logic       out_sof;
  logic       out_eol;

  frame_pad_source #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_active (out_active),
    .out_sof    (out_sof),
    .out_eol    (out_eol)
  );

  always #5 clock = ~clock;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state.
  logic [7:0]  q[$];
  int unsigned k = 0;
  bit          running = 1'b0;

  // {in_ready, out_valid, out_active, out_sof, out_eol, out_pixel}
  logic [12:0] obs_vec;
  logic [12:0] exp_vec;
  logic [12:0] msk_vec;
  bit          last_in_fire;
  bit          last_out_fire;

  // One clock: drive inputs, sample at the falling edge, form the
  // expectation from the model, then advance the model across the edge.
  task automatic cycle(input bit rst, input bit iv, input logic [7:0] px, input bit rdy);
    int unsigned row, col;
    bit act, e_valid, e_rdy, nrun;
    logic [7:0] e_pix;
    reset = rst; in_valid = iv; in_pixel = px; out_ready = rdy;
    @(negedge clock);
    obs_vec = {in_ready, out_valid, out_active, out_sof, out_eol, out_pixel};
    e_rdy = (q.size() < DEPTH);
    row = k / TC; col = k % TC;
    act = (row < AR) && (col < AC);
    if (!running) begin
      e_valid = 1'b0;
      exp_vec = {e_rdy, 12'h000};
      msk_vec = '1;
    end else begin
      e_valid = !act || (q.size() > 0);
      e_pix   = (act && e_valid) ? q[0] : 8'h00;
      exp_vec = {e_rdy, e_valid, act && e_valid, (k == 0) && e_valid,
                 (col == TC - 1) && e_valid, e_pix};
      msk_vec = e_valid ? 13'h1FFF : 13'b1_1_0_1_1_0000_0000;
    end
    last_in_fire  = iv && e_rdy;
    last_out_fire = e_valid && rdy;
    if (rst) begin
      q.delete(); k = 0; running = 1'b0;
      last_in_fire = 1'b0; last_out_fire = 1'b0;
    end else begin
      nrun = running || (q.size() > 0);
      if (last_out_fire) begin
        if (act) void'(q.pop_front());
        k = (k + 1) % (TC * TR);
      end
      if (last_in_fire) q.push_back(px);
      running = nrun;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 8'h00, 0);  // pre-reset state is unknown, not compared
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 8'h00, 1);
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL reset_hold got=%h want=%h mask=%h t=%0t", obs_vec, exp_vec, msk_vec, $time);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 8'($urandom), 1);
      vectors++;
      if (obs_vec !== 13'h1000) begin
        miscompares++;
        $display("FAIL reset_idle got=%h want=%h t=%0t", obs_vec, 13'h1000, $time);
      end
    end
  endtask

  task automatic test_first_pixel();
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'hA5, 1);
    vectors++;
    if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
      miscompares++;
      $display("FAIL first_accept got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
    end
    cycle(0, 0, 8'h00, 1);
    vectors++;
    if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
      miscompares++;
      $display("FAIL first_idle got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
    end
    cycle(0, 0, 8'h00, 1);
    vectors++;
    if (obs_vec !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL first_beat got=%h want=%h t=%0t", obs_vec, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5}, $time);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0]  v = 8'h00;
    int unsigned sofs = 0, beats = 0, actives = 0, eols = 0;
    bit          bad_blank = 1'b0;
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 3 * TC * TR && sofs < 2; i++) begin
      cycle(0, 1, v, 1);
      if (last_in_fire) v = v + 8'd1;
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL frame_beat got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
      if (obs_vec[11]) begin
        if (obs_vec[9]) sofs++;
        if (sofs == 1) begin
          beats++;
          if (obs_vec[10]) actives++;
          if (obs_vec[8]) eols++;
          if (!obs_vec[10] && obs_vec[7:0] !== 8'h00) bad_blank = 1'b1;
        end
      end
    end
    vectors++;
    if (sofs != 2 || beats != TC * TR) begin
      miscompares++;
      $display("FAIL frame_total sofs=%0d beats=%0d want beats=%0d", sofs, beats, TC * TR);
    end
    vectors++;
    if (actives != AC * AR) begin
      miscompares++;
      $display("FAIL frame_active got=%0d want=%0d", actives, AC * AR);
    end
    vectors++;
    if (eols != TR || bad_blank) begin
      miscompares++;
      $display("FAIL frame_eol_blank eols=%0d want=%0d nonzero_blank=%0d", eols, TR, bad_blank);
    end
  endtask

  task automatic test_backpressure();
    int unsigned accepts = 0, drained = 0;
    logic [12:0] held;
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 8'(8'h10 + i), 0);
      if (obs_vec[12]) accepts++;
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL bp_fill got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
    end
    vectors++;
    if (accepts != DEPTH || obs_vec[12] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accepts got=%0d want=%0d in_ready=%b", accepts, DEPTH, obs_vec[12]);
    end
    held = obs_vec;
    cycle(0, 0, 8'h00, 0);
    vectors++;
    if (obs_vec[11:0] !== held[11:0] || held[11] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stable got=%h want=%h", obs_vec[11:0], held[11:0]);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 8'h00, 1);
      if (obs_vec[11] && obs_vec[10]) drained++;
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL bp_drain got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
    end
    vectors++;
    if (drained != DEPTH) begin
      miscompares++;
      $display("FAIL bp_drained got=%0d want=%0d", drained, DEPTH);
    end
  endtask

  task automatic test_starve();
    int unsigned fed = 0, n = 0;
    bit seen = 1'b0;
    cycle(1, 0, 8'h00, 1);
    while (k != 2 * TC + 5 && n < 400) begin
      cycle(0, fed < 2 * AC + 5, 8'($urandom), 1);
      if (last_in_fire) fed++;
      n++;
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL starve_run got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
    end
    vectors++;
    if (k != 2 * TC + 5) begin
      miscompares++;
      $display("FAIL starve_reach got=%0d want=%0d", k, 2 * TC + 5);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 8'h00, 1);
      vectors++;
      if (obs_vec[11] !== 1'b0 || (obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL starve_hold got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
    end
    cycle(0, 1, 8'h77, 1);
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle(0, 0, 8'h00, 1);
      if (obs_vec[11]) begin
        seen = 1'b1;
        vectors++;
        if (obs_vec[11:0] !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h77}) begin
          miscompares++;
          $display("FAIL starve_resume got=%h want=%h", obs_vec[11:0], {1'b1, 1'b1, 1'b0, 1'b0, 8'h77});
        end
      end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL starve_timeout got=no beat want=pixel 77");
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned n = 0;
    cycle(1, 0, 8'h00, 1);
    while (k != 3 * TC + 4 && n < 400) begin
      cycle(0, 1, 8'($urandom), 1);
      n++;
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL mid_run got=%h want=%h t=%0t", obs_vec, exp_vec, $time);
      end
    end
    n = 0;
    do begin
      cycle(0, 1, 8'($urandom), 0);
      n++;
    end while (obs_vec[12] !== 1'b0 && n < 10);
    vectors++;
    if (obs_vec[12] !== 1'b0 || k != 3 * TC + 4) begin
      miscompares++;
      $display("FAIL mid_full in_ready=%b beat=%0d want in_ready=0 beat=%0d", obs_vec[12], k, 3 * TC + 4);
    end
    cycle(1, 1, 8'hEE, 1);
    cycle(1, 0, 8'h00, 1);
    vectors++;
    if (obs_vec !== 13'h1000) begin
      miscompares++;
      $display("FAIL mid_reset got=%h want=%h", obs_vec, 13'h1000);
    end
    cycle(0, 1, 8'h3C, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    vectors++;
    if (obs_vec !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C}) begin
      miscompares++;
      $display("FAIL mid_sof got=%h want=%h", obs_vec, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C});
    end
  endtask

  task automatic test_random();
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 1500; i++) begin
      cycle(0, $urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(9, 0) < 7);
      vectors++;
      if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
        miscompares++;
        $display("FAIL random_beat got=%h want=%h mask=%h t=%0t", obs_vec, exp_vec, msk_vec, $time);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_full_frame();
    test_backpressure();
    test_starve();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
